uart_rx_handshake: RTL and testbench



---
 rtl/uart_rx_handshake.sv | 95 +++++++++
 tb/tb_uart_rx_handshake.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_handshake.sv
// uart_rx_handshake: 8N1 UART receiver with valid/ready output register and framing/overrun flags
module uart_rx_handshake #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       busy
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t        state;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          deliver;
  logic          bit_end;
  logic          half_end;
  assign rx_s     = sync[1];
  assign bit_end  = cnt == CW'(CLKS_PER_BIT - 1);
  assign half_end = cnt == CW'(HALF_BIT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rxd};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      deliver     <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      deliver     <= 1'b0;
      framing_err <= 1'b0;
      busy        <= state != IDLE;
      cnt         <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START:
          if (half_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end
        DATA:
          if (bit_end) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        STOP:
          if (bit_end) begin
            cnt         <= '0;
            deliver     <= rx_s;
            framing_err <= !rx_s;
            state       <= rx_s ? IDLE : BREAK;
          end
        BREAK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= deliver && data_valid && !data_ready;
      if (deliver && (!data_valid || data_ready)) begin
        data_out   <= shift;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_handshake.sv
// tb_uart_rx_handshake: randomized self-checking bench with a queue-based scoreboard
module tb_uart_rx_handshake;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b0;
  logic data_ready = 1'b0;
  logic [7:0] data_out;
  logic data_valid, framing_err, overrun_err, busy;
  int pass_n = 0, tot_n = 0;
  int cyc = 0, fe_n = 0, ov_n = 0, dvr_n = 0, clash_n = 0;
  logic dv_q = 1'b0;
  logic [7:0] got_q[$];
  uart_rx_handshake #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .framing_err(framing_err), .overrun_err(overrun_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (data_valid && data_ready) got_q.push_back(data_out);
    if (framing_err) fe_n++;
    if (overrun_err) ov_n++;
    if (data_valid && !dv_q) dvr_n++;
    if ((framing_err && overrun_err) || ((framing_err || overrun_err) && data_valid && !dv_q)) clash_n++;
    dv_q = data_valid;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic bit_out(input logic v);
    rxd = v;
    wait_cyc(CPB);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
  endtask
  task automatic drain();
    data_ready = 1'b1;
    wait_cyc(1);
    data_ready = 1'b0;
  endtask
  task automatic test_reset();
    rxd = 1'b0;
    rst = 1'b1;
    wait_cyc(5);
    tot_n++; if (data_out !== 8'h00) $display("FAIL rst_data: got %h want 00", data_out); else pass_n++;
    tot_n++; if (data_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", data_valid); else pass_n++;
    tot_n++; if (framing_err !== 1'b0 || overrun_err !== 1'b0) $display("FAIL rst_err: got %b%b want 00", framing_err, overrun_err); else pass_n++;
    tot_n++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_n++;
    rst = 1'b0;
    rxd = 1'b1;
    wait_cyc(10);
    tot_n++; if (busy !== 1'b0) $display("FAIL rst_no_spurious_start: got busy %b want 0", busy); else pass_n++;
  endtask
  task automatic test_basic();
    int c0, lat, fe0, ov0;
    logic pb, b_at;
    logic [7:0] b;
    fe0 = fe_n;
    ov0 = ov_n;
    data_ready = 1'b0;
    c0 = cyc;
    lat = -1;
    pb = 1'b0;
    b_at = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 300; i++) begin
          @(posedge clk);
          #1;
          if (data_valid) begin
            lat = cyc - c0;
            b_at = busy;
            break;
          end
          pb = busy;
        end
      end
    join
    tot_n++; if (lat < 150 || lat > 160) $display("FAIL basic_latency: got %0d want 150..160", lat); else pass_n++;
    tot_n++; if (pb !== 1'b1 || b_at !== 1'b0) $display("FAIL basic_busy_fall: got before=%b at=%b want 1 0", pb, b_at); else pass_n++;
    tot_n++; if (data_out !== 8'hA5) $display("FAIL basic_data: got %h want a5", data_out); else pass_n++;
    tot_n++; if (data_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", data_valid); else pass_n++;
    tot_n++; if (fe_n != fe0 || ov_n != ov0) $display("FAIL basic_err: got fe=%0d ov=%0d want 0 0", fe_n - fe0, ov_n - ov0); else pass_n++;
    drain();
    tot_n++; if (data_valid !== 1'b0 || data_out !== 8'hA5) $display("FAIL basic_drain: got v=%b d=%h want 0 a5", data_valid, data_out); else pass_n++;
    b = 8'($urandom);
    send_frame(b, 1'b1);
    wait_cyc(2);
    tot_n++; if (data_out !== b || data_valid !== 1'b1) $display("FAIL basic_rand: got v=%b d=%h want 1 %h", data_valid, data_out, b); else pass_n++;
    drain();
  endtask
  task automatic test_glitch();
    int fe0, ov0, dv0;
    fe0 = fe_n;
    ov0 = ov_n;
    dv0 = dvr_n;
    rxd = 1'b0;
    wait_cyc(4);
    rxd = 1'b1;
    wait_cyc(2);
    tot_n++; if (busy !== 1'b1) $display("FAIL glitch_busy: got %b want 1", busy); else pass_n++;
    wait_cyc(40);
    tot_n++; if (busy !== 1'b0) $display("FAIL glitch_idle: got busy %b want 0", busy); else pass_n++;
    tot_n++; if (dvr_n != dv0 || fe_n != fe0 || ov_n != ov0) $display("FAIL glitch_flags: got dv=%0d fe=%0d ov=%0d want 0 0 0", dvr_n - dv0, fe_n - fe0, ov_n - ov0); else pass_n++;
  endtask
  task automatic test_framing();
    int fe0, dv0, n;
    fe0 = fe_n;
    dv0 = dvr_n;
    send_frame(8'h3C, 1'b0);
    wait_cyc(40);
    tot_n++; if (fe_n - fe0 != 1) $display("FAIL framing_count: got %0d want 1", fe_n - fe0); else pass_n++;
    tot_n++; if (busy !== 1'b1) $display("FAIL framing_busy: got %b want 1", busy); else pass_n++;
    tot_n++; if (dvr_n != dv0 || data_valid !== 1'b0) $display("FAIL framing_valid: got %b want 0", data_valid); else pass_n++;
    rxd = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      wait_cyc(1);
      n++;
    end
    tot_n++; if (n < 2 || n > 5) $display("FAIL framing_release: got %0d cycles want 2..5", n); else pass_n++;
    wait_cyc(CPB);
    tot_n++; if (fe_n - fe0 != 1) $display("FAIL framing_single: got %0d want 1", fe_n - fe0); else pass_n++;
  endtask
  task automatic test_overrun();
    int fe0, ov0;
    fe0 = fe_n;
    ov0 = ov_n;
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_cyc(4);
    tot_n++; if (data_out !== 8'h11 || data_valid !== 1'b1) $display("FAIL overrun_keep: got v=%b d=%h want 1 11", data_valid, data_out); else pass_n++;
    tot_n++; if (ov_n - ov0 != 1 || fe_n != fe0) $display("FAIL overrun_count: got ov=%0d fe=%0d want 1 0", ov_n - ov0, fe_n - fe0); else pass_n++;
    drain();
    tot_n++; if (data_valid !== 1'b0 || data_out !== 8'h11) $display("FAIL overrun_drain: got v=%b d=%h want 0 11", data_valid, data_out); else pass_n++;
    tot_n++; if (got_q.size() == 0 || got_q[got_q.size()-1] !== 8'h11) $display("FAIL overrun_accept: got size %0d want last 11", got_q.size()); else pass_n++;
  endtask
  task automatic run_stream(input string name, input logic [7:0] bytes[$], input bit rand_err);
    logic [7:0] exp_q[$];
    int base, fe0, ov0, n_err;
    logic err;
    base = got_q.size();
    fe0 = fe_n;
    ov0 = ov_n;
    n_err = 0;
    data_ready = 1'b1;
    foreach (bytes[i]) begin
      err = rand_err && ($urandom_range(0, 3) == 0);
      send_frame(bytes[i], !err);
      if (err) begin
        n_err++;
        wait_cyc($urandom_range(0, 30));
        rxd = 1'b1;
        bit_out(1'b1);
      end else begin
        exp_q.push_back(bytes[i]);
      end
      if (rand_err) wait_cyc($urandom_range(0, 20));
    end
    wait_cyc(4);
    data_ready = 1'b0;
    tot_n++; if (got_q.size() - base != exp_q.size()) $display("FAIL %s_count: got %0d want %0d", name, got_q.size() - base, exp_q.size()); else pass_n++;
    foreach (exp_q[i])
      if (base + i < got_q.size()) begin
        tot_n++; if (got_q[base+i] !== exp_q[i]) $display("FAIL %s_byte%0d: got %h want %h", name, i, got_q[base+i], exp_q[i]); else pass_n++;
      end
    tot_n++; if (fe_n - fe0 != n_err || ov_n != ov0) $display("FAIL %s_err: got fe=%0d ov=%0d want %0d 0", name, fe_n - fe0, ov_n - ov0, n_err); else pass_n++;
  endtask
  task automatic test_random();
    logic [7:0] q[$];
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
    run_stream("random", q, 1'b1);
  endtask
  task automatic test_back_to_back();
    logic [7:0] q[$];
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'h55);
    run_stream("stream", q, 1'b0);
  endtask
  task automatic test_reset_mid();
    int fe0;
    data_ready = 1'b0;
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    wait_cyc(CPB / 2);
    tot_n++; if (busy !== 1'b1 || data_out !== 8'h55) $display("FAIL midrst_pre: got busy=%b d=%h want 1 55", busy, data_out); else pass_n++;
    rst = 1'b1;
    #1;
    tot_n++; if (data_out !== 8'h00 || data_valid !== 1'b0) $display("FAIL midrst_out: got v=%b d=%h want 0 00", data_valid, data_out); else pass_n++;
    tot_n++; if (busy !== 1'b0 || framing_err !== 1'b0 || overrun_err !== 1'b0) $display("FAIL midrst_flags: got %b%b%b want 000", busy, framing_err, overrun_err); else pass_n++;
    rxd = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(20 * CPB);
    fe0 = fe_n;
    send_frame(8'h7E, 1'b1);
    wait_cyc(4);
    tot_n++; if (data_out !== 8'h7E || data_valid !== 1'b1) $display("FAIL midrst_recover: got v=%b d=%h want 1 7e", data_valid, data_out); else pass_n++;
    tot_n++; if (fe_n != fe0) $display("FAIL midrst_err: got %0d want 0", fe_n - fe0); else pass_n++;
    drain();
  endtask
  task automatic test_exclusive();
    tot_n++; if (clash_n != 0) $display("FAIL pulse_exclusive: got %0d clashes want 0", clash_n); else pass_n++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_exclusive();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
